// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder: default bus widths, FSM states and debug status codes.
package sram_responder_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ_WAIT,
        ST_READ_DRIVE,
        ST_WRITE_ACTIVE
    } state_t;

    localparam logic [7:0] CODE_INIT         = 8'h01;
    localparam logic [7:0] CODE_IDLE         = 8'h00;
    localparam logic [7:0] CODE_READ_WAIT    = 8'h51;
    localparam logic [7:0] CODE_READ_DRIVE   = 8'h52;
    localparam logic [7:0] CODE_WRITE_ACTIVE = 8'h61;

    function automatic logic [7:0] status_code(input state_t s);
        case (s)
            ST_INIT:         status_code = CODE_INIT;
            ST_READ_WAIT:    status_code = CODE_READ_WAIT;
            ST_READ_DRIVE:   status_code = CODE_READ_DRIVE;
            ST_WRITE_ACTIVE: status_code = CODE_WRITE_ACTIVE;
            default:         status_code = CODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sram_array.sv
// Word array behind the responder: one synchronous write port, one combinational read port.
module sram_array import sram_responder_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sram_responder.sv
// Clocked stand-in for the external asynchronous SRAM: decodes EN/OE/WE strobe sequences from the
// CPU-side controller into array reads and writes, and drives the shared data bus on reads.
module sram_responder import sram_responder_pkg::*; #(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                MEM_AW     = 10,
    parameter int                READ_LAT   = 1,
    parameter int                INIT_CLEAR = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    input  logic              sram_en_n,
    input  logic              sram_oe_n,
    input  logic              sram_we_n,
    output logic              init_done,
    output logic              protocol_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic [7:0]        status_out
);

    localparam int DEPTH = 2**MEM_AW;
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

    state_t            state;
    logic [MEM_AW-1:0] init_addr;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [MEM_AW-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_wdata;
    logic [MEM_AW-1:0] mem_waddr;
    logic              mem_we;
    logic              wr_req, rd_req, conflict, init_access;
    logic              addr_changed, rd_fire, commit, drive_en;

    assign wr_req       = ~sram_en_n & ~sram_we_n;
    assign rd_req       = ~sram_en_n & ~sram_oe_n & sram_we_n;
    assign conflict     = ~sram_en_n & ~sram_oe_n & ~sram_we_n;
    assign init_access  = (state == ST_INIT) & ~sram_en_n & (~sram_oe_n | ~sram_we_n);
    assign addr_changed = (sram_addr != rd_addr_q);
    assign rd_fire      = (state == ST_READ_WAIT) & rd_req & ~addr_changed & (lat_cnt == LAT_LAST);
    assign commit       = (state == ST_WRITE_ACTIVE) & ~wr_req;

    // Drive enable is combinational on the strobes so the bus is released the moment they drop.
    assign drive_en   = (state == ST_READ_DRIVE) & rd_req;
    assign sram_data  = drive_en ? rd_q : 'z;
    assign status_out = status_code(state);

    // The init sweep and write commits share the single write port; they never overlap.
    assign mem_we    = ((state == ST_INIT) && (INIT_CLEAR != 0)) || commit;
    assign mem_waddr = (state == ST_INIT) ? init_addr : addr_q;
    assign mem_wdata = (state == ST_INIT) ? INIT_VALUE : data_q;

    sram_array #(
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_array (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata),
        .raddr  (sram_addr[MEM_AW-1:0]),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_INIT;
            init_addr    <= '0;
            lat_cnt      <= '0;
            init_done    <= 1'b0;
            protocol_err <= 1'b0;
            rd_count     <= '0;
            wr_count     <= '0;
        end else begin
            if (conflict || init_access) begin
                protocol_err <= 1'b1;
            end
            case (state)
                ST_INIT: begin
                    if ((INIT_CLEAR == 0) || (init_addr == MEM_AW'(DEPTH - 1))) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end else begin
                        init_addr <= init_addr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (wr_req) begin
                        state <= ST_WRITE_ACTIVE;
                    end else if (rd_req) begin
                        state   <= ST_READ_WAIT;
                        lat_cnt <= '0;
                    end
                end
                ST_READ_WAIT: begin
                    if (wr_req) begin
                        state <= ST_WRITE_ACTIVE;
                    end else if (!rd_req) begin
                        state <= ST_IDLE;
                    end else if (addr_changed) begin
                        lat_cnt <= '0;
                    end else if (rd_fire) begin
                        state    <= ST_READ_DRIVE;
                        rd_count <= rd_count + 16'd1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_READ_DRIVE: begin
                    if (wr_req) begin
                        state <= ST_WRITE_ACTIVE;
                    end else if (!rd_req) begin
                        state <= ST_IDLE;
                    end else if (addr_changed) begin
                        state   <= ST_READ_WAIT;
                        lat_cnt <= '0;
                    end
                end
                ST_WRITE_ACTIVE: begin
                    if (commit) begin
                        state    <= ST_IDLE;
                        wr_count <= wr_count + 16'd1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Datapath registers carry no reset; rd_addr_q tracks the previous cycle's address.
    always_ff @(posedge clk) begin
        rd_addr_q <= sram_addr;
        if (wr_req && (state != ST_INIT)) begin
            addr_q <= sram_addr[MEM_AW-1:0];
            data_q <= sram_data;
        end
        if (rd_fire) begin
            rd_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Randomised bench for sram_responder with a word-array reference model of the SRAM contents.
module tb_sram_responder;

    localparam int ADDR_W   = 18;
    localparam int DATA_W   = 16;
    localparam int MEM_AW   = 4;
    localparam int DEPTH    = 16;
    localparam int READ_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] sram_addr = '0;
    logic              sram_en_n = 1'b1;
    logic              sram_oe_n = 1'b1;
    logic              sram_we_n = 1'b1;
    logic              tb_drive  = 1'b0;
    logic [DATA_W-1:0] tb_data   = '0;
    wire  [DATA_W-1:0] sram_data;
    logic              init_done, protocol_err;
    logic [15:0]       rd_count, wr_count;
    logic [7:0]        status_out;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                ref_rd, ref_wr;
    logic              ref_err;
    int                errors = 0;
    int                checks = 0;

    assign sram_data = tb_drive ? tb_data : 'z;

    always #5 clk = ~clk;

    sram_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_AW     (MEM_AW),
        .READ_LAT   (READ_LAT),
        .INIT_CLEAR (1),
        .INIT_VALUE (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sram_addr    (sram_addr),
        .sram_data    (sram_data),
        .sram_en_n    (sram_en_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .init_done    (init_done),
        .protocol_err (protocol_err),
        .rd_count     (rd_count),
        .wr_count     (wr_count),
        .status_out   (status_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        sram_en_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        tb_drive  = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        ref_rd  = 0;
        ref_wr  = 0;
        ref_err = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        sram_addr = a;
        tb_data   = d;
        tb_drive  = 1'b1;
        sram_oe_n = 1'b1;
        sram_en_n = 1'b0;
        sram_we_n = 1'b0;
        step();
        sram_we_n = 1'b1;
        step();
        bus_idle();
        ref_mem[a[MEM_AW-1:0]] = d;
        ref_wr++;
    endtask

    // Leaves the strobes asserted and returns at a falling edge once data is being driven.
    task automatic open_read(input logic [ADDR_W-1:0] a, output int lat);
        sram_addr = a;
        tb_drive  = 1'b0;
        sram_we_n = 1'b1;
        sram_en_n = 1'b0;
        sram_oe_n = 1'b0;
        lat = 0;
        @(negedge clk);
        while (status_out !== 8'h52 && lat < 20) begin
            step();
            lat++;
            @(negedge clk);
        end
        ref_rd++;
    endtask

    task automatic read_word(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] got,
                             output int lat);
        open_read(a, lat);
        got = sram_data;
        sram_en_n = 1'b1;
        sram_oe_n = 1'b1;
        step();
    endtask

    task automatic wait_init(input bit poke, output int n);
        n = 0;
        step();
        rst = 1'b1;
        while (init_done !== 1'b1 && n < 200) begin
            sram_en_n = (poke && n == 2) ? 1'b0 : 1'b1;
            sram_oe_n = (poke && n == 2) ? 1'b0 : 1'b1;
            step();
            n++;
        end
        bus_idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus_idle();
        model_reset();
        repeat (3) step();
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", protocol_err); end
        checks++; if (rd_count !== 16'h0) begin errors++; $display("FAIL reset_rd_count: got %h expected 0000", rd_count); end
        checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL reset_wr_count: got %h expected 0000", wr_count); end
        checks++; if (status_out !== 8'h01) begin errors++; $display("FAIL reset_status: got %h expected 01", status_out); end
        step();
        rst = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            checks++;
            if (init_done !== 1'(i == DEPTH)) begin
                errors++;
                $display("FAIL init_sweep_cycle%0d: got init_done=%b expected %b", i, init_done, (i == DEPTH));
            end
        end
        checks++; if (status_out !== 8'h00) begin errors++; $display("FAIL idle_status: got %h expected 00", status_out); end
    endtask

    task automatic test_init_read();
        logic [DATA_W-1:0] got;
        int lat;
        read_word(18'h3FFF7, got, lat);
        checks++; if (got !== 16'h0000) begin errors++; $display("FAIL init_read_data: got %h expected 0000", got); end
        checks++; if (rd_count !== 16'(ref_rd)) begin errors++; $display("FAIL init_read_count: got %0d expected %0d", rd_count, ref_rd); end
    endtask

    task automatic test_write_read();
        do_write(18'h00005, 16'hBEEF);
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL write_count: got %0d expected 1", wr_count); end
        sram_addr = 18'h00005;
        sram_en_n = 1'b0;
        sram_oe_n = 1'b0;
        for (int c = 0; c <= READ_LAT; c++) begin
            @(negedge clk);
            checks++;
            if (sram_data === 16'hBEEF) begin
                errors++;
                $display("FAIL read_latency_sample%0d: got %h expected released bus", c, sram_data);
            end
            step();
        end
        @(negedge clk);
        ref_rd++;
        checks++; if (sram_data !== 16'hBEEF) begin errors++; $display("FAIL read_data: got %h expected beef", sram_data); end
        checks++; if (rd_count !== 16'(ref_rd)) begin errors++; $display("FAIL read_count: got %0d expected %0d", rd_count, ref_rd); end
        sram_oe_n = 1'b1;
        #1;
        checks++; if (sram_data === 16'hBEEF) begin errors++; $display("FAIL oe_release: got %h expected released bus", sram_data); end
        checks++; if (status_out !== 8'h52) begin errors++; $display("FAIL oe_release_state: got %h expected 52", status_out); end
        sram_en_n = 1'b1;
        step();
        checks++; if (status_out !== 8'h00) begin errors++; $display("FAIL read_end_status: got %h expected 00", status_out); end
    endtask

    task automatic test_alias();
        logic [DATA_W-1:0] got;
        int lat;
        do_write(18'h12345, 16'h00AA);
        read_word(18'h00345, got, lat);
        checks++; if (got !== ref_mem[5]) begin errors++; $display("FAIL alias_data: got %h expected %h", got, ref_mem[5]); end
        checks++; if (lat !== READ_LAT + 1) begin errors++; $display("FAIL alias_latency: got %0d expected %0d", lat, READ_LAT + 1); end
    endtask

    task automatic test_addr_change();
        int lat;
        do_write(18'h00001, 16'h1111);
        do_write(18'h00002, 16'h2222);
        open_read(18'h00001, lat);
        checks++; if (sram_data !== 16'h1111) begin errors++; $display("FAIL chg_first_data: got %h expected 1111", sram_data); end
        step();
        sram_addr = 18'h00002;
        for (int c = 0; c < READ_LAT; c++) begin
            step();
            @(negedge clk);
            checks++;
            if (sram_data === 16'h1111 || sram_data === 16'h2222) begin
                errors++;
                $display("FAIL chg_gap_sample%0d: got %h expected released bus", c, sram_data);
            end
            checks++; if (rd_count !== 16'(ref_rd)) begin errors++; $display("FAIL chg_gap_count: got %0d expected %0d", rd_count, ref_rd); end
        end
        step();
        @(negedge clk);
        ref_rd++;
        checks++; if (sram_data !== 16'h2222) begin errors++; $display("FAIL chg_new_data: got %h expected 2222", sram_data); end
        checks++; if (rd_count !== 16'(ref_rd)) begin errors++; $display("FAIL chg_count: got %0d expected %0d", rd_count, ref_rd); end
        sram_en_n = 1'b1;
        sram_oe_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d, got;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
            d = DATA_W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d);
                checks++; if (wr_count !== 16'(ref_wr)) begin errors++; $display("FAIL rand_wr_count%0d: got %0d expected %0d", i, wr_count, ref_wr); end
            end else begin
                read_word(a, got, lat);
                checks++; if (got !== ref_mem[a[MEM_AW-1:0]]) begin errors++; $display("FAIL rand_rd_data%0d: addr %h got %h expected %h", i, a, got, ref_mem[a[MEM_AW-1:0]]); end
                checks++; if (lat !== READ_LAT + 1) begin errors++; $display("FAIL rand_rd_lat%0d: got %0d expected %0d", i, lat, READ_LAT + 1); end
                checks++; if (rd_count !== 16'(ref_rd)) begin errors++; $display("FAIL rand_rd_count%0d: got %0d expected %0d", i, rd_count, ref_rd); end
            end
            repeat ($urandom_range(0, 2)) step();
        end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL rand_no_perr: got %b expected 0", protocol_err); end
    endtask

    task automatic test_conflict();
        logic [DATA_W-1:0] got;
        int lat;
        do_write(18'h00003, 16'h3333);
        open_read(18'h00003, lat);
        checks++; if (sram_data !== 16'h3333) begin errors++; $display("FAIL conf_pre_data: got %h expected 3333", sram_data); end
        tb_data   = 16'h5A5A;
        tb_drive  = 1'b1;
        sram_we_n = 1'b0;
        #1;
        checks++; if (sram_data !== 16'h5A5A) begin errors++; $display("FAIL conf_release: got %h expected 5a5a", sram_data); end
        step();
        ref_err = 1'b1;
        checks++; if (protocol_err !== ref_err) begin errors++; $display("FAIL conf_perr: got %b expected 1", protocol_err); end
        checks++; if (status_out !== 8'h61) begin errors++; $display("FAIL conf_state: got %h expected 61", status_out); end
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        step();
        bus_idle();
        ref_mem[3] = 16'h5A5A;
        ref_wr++;
        checks++; if (wr_count !== 16'(ref_wr)) begin errors++; $display("FAIL conf_wr_count: got %0d expected %0d", wr_count, ref_wr); end
        read_word(18'h00003, got, lat);
        checks++; if (got !== 16'h5A5A) begin errors++; $display("FAIL conf_commit: got %h expected 5a5a", got); end
        checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL conf_sticky: got %b expected 1", protocol_err); end
    endtask

    task automatic test_reset_mid_op();
        logic [DATA_W-1:0] got;
        int lat, n;
        do_write(18'h00009, 16'hC3C3);
        open_read(18'h00009, lat);
        checks++; if (sram_data !== 16'hC3C3) begin errors++; $display("FAIL rst_pre_data: got %h expected c3c3", sram_data); end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++; if (sram_data === 16'hC3C3) begin errors++; $display("FAIL rst_release: got %h expected released bus", sram_data); end
        checks++; if (status_out !== 8'h01) begin errors++; $display("FAIL rst_status: got %h expected 01", status_out); end
        checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL rst_perr_clear: got %b expected 0", protocol_err); end
        checks++; if (rd_count !== 16'h0) begin errors++; $display("FAIL rst_rd_count: got %0d expected 0", rd_count); end
        bus_idle();
        wait_init(1'b0, n);
        checks++; if (n !== DEPTH) begin errors++; $display("FAIL rst_reinit_cycles: got %0d expected %0d", n, DEPTH); end
        sram_addr = 18'h0000A;
        tb_data   = 16'h7777;
        tb_drive  = 1'b1;
        sram_en_n = 1'b0;
        sram_we_n = 1'b0;
        step();
        checks++; if (status_out !== 8'h61) begin errors++; $display("FAIL rst_wa_state: got %h expected 61", status_out); end
        #3;
        rst = 1'b0;
        #1;
        checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL rst_no_commit_count: got %0d expected 0", wr_count); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
        bus_idle();
        wait_init(1'b1, n);
        ref_err = 1'b1;
        checks++; if (n !== DEPTH) begin errors++; $display("FAIL rst_sweep_cycles: got %0d expected %0d", n, DEPTH); end
        checks++; if (protocol_err !== ref_err) begin errors++; $display("FAIL init_access_perr: got %b expected 1", protocol_err); end
        read_word(18'h0000A, got, lat);
        checks++; if (got !== ref_mem[10]) begin errors++; $display("FAIL rst_no_commit_data: got %h expected %h", got, ref_mem[10]); end
        read_word(18'h00009, got, lat);
        checks++; if (got !== ref_mem[9]) begin errors++; $display("FAIL rst_cleared_data: got %h expected %h", got, ref_mem[9]); end
        checks++; if (rd_count !== 16'(ref_rd)) begin errors++; $display("FAIL rst_final_rd_count: got %0d expected %0d", rd_count, ref_rd); end
        checks++; if (wr_count !== 16'(ref_wr)) begin errors++; $display("FAIL rst_final_wr_count: got %0d expected %0d", wr_count, ref_wr); end
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_write_read();
        test_alias();
        test_addr_change();
        test_random();
        test_conflict();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
        $fatal(1);
    end

endmodule
